// File: rtl/cache_arbiter_pkg.sv
// Shared types for the cache arbiter: arbiter FSM states, the cache line
// width and a small saturating-increment helper for the starvation counter.
package rv32i_types;

  localparam int unsigned LINE_WIDTH = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  // Increment a 3-bit count, sticking at all-ones instead of wrapping.
  function automatic logic [2:0] sat_inc3(input logic [2:0] value);
    return (value == 3'b111) ? value : value + 3'd1;
  endfunction

endpackage

// File: rtl/cache_arbiter_perf_counter.sv
// arb_perf_counter: 32-bit saturating event counter with an async active-low
// reset. Used by cache_arbiter only when CACHE_ARB_PERF_EN is defined.
module arb_perf_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [31:0] count
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  // Next count: step by one on inc, hold once the counter is full.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares the single physical-memory line port between the
// I-cache and the D-cache. D-side misses are preferred because they stall the
// whole pipeline; a starvation counter forces an I grant after STARVE_LIMIT
// consecutive D grants taken while the I-cache was waiting.
// Optional build macro: CACHE_ARB_PERF_EN enables the grant/wait performance
// counters; without it the perf outputs are constant zero.
module cache_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned LINE_W       = LINE_WIDTH
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              icache_read,
  input  logic [31:0]       icache_address,
  output logic [LINE_W-1:0] icache_rdata,
  output logic              icache_resp,

  input  logic              dcache_read,
  input  logic              dcache_write,
  input  logic [31:0]       dcache_address,
  input  logic [LINE_W-1:0] dcache_wdata,
  output logic [LINE_W-1:0] dcache_rdata,
  output logic              dcache_resp,

  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,

  output logic [31:0]       perf_i_grants,
  output logic [31:0]       perf_d_grants,
  output logic [31:0]       perf_i_wait
);

  arb_state_t        state_q, state_d;
  logic              pmem_read_q, pmem_read_d;
  logic              pmem_write_q, pmem_write_d;
  logic [31:0]       pmem_addr_q, pmem_addr_d;
  logic [LINE_W-1:0] pmem_wdata_q, pmem_wdata_d;
  logic [2:0]        starve_cnt_q, starve_cnt_d;

  logic d_req;
  logic d_under_limit;
  logic grant_i;
  logic grant_d;

  assign d_req         = dcache_read | dcache_write;
  assign d_under_limit = (32'(starve_cnt_q) < STARVE_LIMIT);

  // Grant decision, completion routing and next state. A response only
  // reaches the side currently being served; the other side sees zeros.
  always_comb begin
    state_d      = state_q;
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    icache_resp  = 1'b0;
    dcache_resp  = 1'b0;
    icache_rdata = '0;
    dcache_rdata = '0;
    unique case (state_q)
      IDLE: begin
        if (d_req && d_under_limit) begin
          grant_d = 1'b1;
          state_d = SERVE_D;
        end else if (icache_read) begin
          grant_i = 1'b1;
          state_d = SERVE_I;
        end else if (d_req) begin
          grant_d = 1'b1;
          state_d = SERVE_D;
        end
      end
      SERVE_I: begin
        if (pmem_resp) begin
          icache_resp  = 1'b1;
          icache_rdata = pmem_rdata;
          state_d      = IDLE;
        end
      end
      SERVE_D: begin
        if (pmem_resp) begin
          dcache_resp  = 1'b1;
          dcache_rdata = pmem_rdata;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant registers and starvation counter: capture the winner's command at
  // grant so requester-side changes cannot disturb an in-flight transfer.
  always_comb begin
    pmem_read_d  = pmem_read_q;
    pmem_write_d = pmem_write_q;
    pmem_addr_d  = pmem_addr_q;
    pmem_wdata_d = pmem_wdata_q;
    starve_cnt_d = starve_cnt_q;
    if (grant_d) begin
      pmem_addr_d  = dcache_address;
      pmem_wdata_d = dcache_wdata;
      pmem_write_d = dcache_write;
      pmem_read_d  = ~dcache_write;
      starve_cnt_d = icache_read ? sat_inc3(starve_cnt_q) : 3'd0;
    end else if (grant_i) begin
      pmem_addr_d  = icache_address;
      pmem_write_d = 1'b0;
      pmem_read_d  = 1'b1;
      starve_cnt_d = 3'd0;
    end else if ((state_q != IDLE) && pmem_resp) begin
      pmem_read_d  = 1'b0;
      pmem_write_d = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant and starvation registers; reset abandons any in-flight command.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      pmem_addr_q  <= '0;
      pmem_wdata_q <= '0;
      starve_cnt_q <= '0;
    end else begin
      pmem_read_q  <= pmem_read_d;
      pmem_write_q <= pmem_write_d;
      pmem_addr_q  <= pmem_addr_d;
      pmem_wdata_q <= pmem_wdata_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_addr_q;
  assign pmem_wdata   = pmem_wdata_q;

`ifdef CACHE_ARB_PERF_EN
  logic i_wait_inc;
  assign i_wait_inc = icache_read & ~icache_resp;

  arb_perf_counter u_perf_i_grants (
    .clk   (clk),
    .rst_n (rst),
    .inc   (grant_i),
    .count (perf_i_grants)
  );

  arb_perf_counter u_perf_d_grants (
    .clk   (clk),
    .rst_n (rst),
    .inc   (grant_d),
    .count (perf_d_grants)
  );

  arb_perf_counter u_perf_i_wait (
    .clk   (clk),
    .rst_n (rst),
    .inc   (i_wait_inc),
    .count (perf_i_wait)
  );
`else
  assign perf_i_grants = '0;
  assign perf_d_grants = '0;
  assign perf_i_wait   = '0;
`endif

`ifndef SYNTHESIS
  a_no_read_and_write: assert property (@(posedge clk) disable iff (!rst)
    !(dcache_read && dcache_write));

  a_no_resp_in_idle: assert property (@(posedge clk) disable iff (!rst)
    (state_q == IDLE) |-> !pmem_resp);
`endif

endmodule
